// File: rtl/output_layer_mac_sched.sv
// Output-layer dot-product sequencer: one shared int4 x int8 multiply per cycle, N_IN+1 cycles per neuron to out_valid.
// Results held stable on out_ready=0; running argmax reported as class_idx with the done pulse.
module output_layer_mac_sched #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 10,
    parameter int ACC_W = 20,
    parameter int AW_A  = $clog2(N_IN),
    parameter int AW_W  = $clog2(N_IN * N_OUT),
    parameter int OW    = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [AW_A-1:0]         act_addr,
    input  logic signed [7:0]       act_data,
    output logic [AW_W-1:0]         w_addr,
    input  logic signed [3:0]       w_data,
    output logic signed [3:0]       mul_a,
    output logic signed [7:0]       mul_b,
    input  logic signed [11:0]      mul_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OW-1:0]           out_idx,
    output logic signed [ACC_W-1:0] out_acc,
    output logic [OW-1:0]           class_idx
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, FIN} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state, state_nxt;
    logic                    issue_d;
    logic signed [ACC_W-1:0] acc, best_val;
    logic [OW-1:0]           o, best_idx;
    logic                    last_i, last_o, acc_gt;
    logic signed [ACC_W-1:0] prod_ext;

    assign last_i   = (act_addr == AW_A'(N_IN - 1));
    assign last_o   = (o == OW'(N_OUT - 1));
    assign acc_gt   = (acc > best_val);
    assign prod_ext = {{(ACC_W-12){mul_y[11]}}, mul_y};

    // Operands are gated by the issue flag so the multiplier sees zeros outside a live read.
    assign mul_a     = issue_d ? w_data : 4'sd0;
    assign mul_b     = issue_d ? act_data : 8'sd0;
    assign busy      = (state == RUN) || (state == DRAIN) || (state == EMIT);
    assign done      = (state == FIN);
    assign out_valid = (state == EMIT);
    assign out_idx   = o;
    assign out_acc   = acc;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_i) state_nxt = DRAIN;
            DRAIN:   state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last_o ? FIN : RUN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_d   <= 1'b0;
            acc       <= '0;
            best_val  <= ACC_MIN;
            best_idx  <= '0;
            o         <= '0;
            act_addr  <= '0;
            w_addr    <= '0;
            class_idx <= '0;
        end else begin
            issue_d <= (state == RUN);
            if (issue_d) acc <= acc + prod_ext;
            case (state)
                IDLE: if (start) begin
                    o        <= '0;
                    acc      <= '0;
                    act_addr <= '0;
                    w_addr   <= '0;
                    best_val <= ACC_MIN;
                    best_idx <= '0;
                end
                // Address registers hold on the last issue so they stay put through DRAIN/EMIT.
                RUN: if (!last_i) begin
                    act_addr <= act_addr + AW_A'(1);
                    w_addr   <= w_addr + AW_W'(1);
                end
                EMIT: if (out_ready) begin
                    if (acc_gt) begin
                        best_val <= acc;
                        best_idx <= o;
                    end
                    if (!last_o) begin
                        o        <= o + OW'(1);
                        acc      <= '0;
                        act_addr <= '0;
                        w_addr   <= w_addr + AW_W'(1);
                    end else begin
                        class_idx <= acc_gt ? o : best_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_mac_sched.sv
// Scoreboard bench for output_layer_mac_sched: directed passes plus randomised passes with backpressure.
module tb_output_layer_mac_sched;

    localparam int N_IN  = 16;
    localparam int N_OUT = 10;
    localparam int ACC_W = 20;
    localparam int AW_A  = 4;
    localparam int AW_W  = 8;
    localparam int OW    = 4;

    logic                    clk = 1'b0;
    logic                    rst, start, out_ready;
    logic                    busy, done, out_valid;
    logic [AW_A-1:0]         act_addr;
    logic [AW_W-1:0]         w_addr;
    logic signed [7:0]       act_data;
    logic signed [3:0]       w_data;
    logic signed [3:0]       mul_a;
    logic signed [7:0]       mul_b;
    logic signed [11:0]      mul_y;
    logic [OW-1:0]           out_idx, class_idx;
    logic signed [ACC_W-1:0] out_acc;

    logic signed [7:0] act_mem [N_IN];
    logic signed [3:0] w_mem   [N_IN*N_OUT];

    typedef struct {int idx; int acc;} exp_t;
    exp_t exp_q[$];
    int   exp_class;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
    end

    assign mul_y = mul_a * mul_b;

    output_layer_mac_sched #(
        .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .AW_A(AW_A), .AW_W(AW_W), .OW(OW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .act_addr(act_addr), .act_data(act_data), .w_addr(w_addr), .w_data(w_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_acc(out_acc), .class_idx(class_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N_IN; i++) act_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_act_addr"}, 64'(act_addr), 64'(0));
        check({tag, "_w_addr"}, 64'(w_addr), 64'(0));
        check({tag, "_out_idx"}, 64'(out_idx), 64'(0));
        check({tag, "_out_acc"}, 64'(out_acc), 64'(0));
        check({tag, "_class"}, 64'(class_idx), 64'(0));
        check({tag, "_mul_a"}, 64'(mul_a), 64'(0));
        check({tag, "_mul_b"}, 64'(mul_b), 64'(0));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge following FIN.
    task automatic run_pass(input int stall_n, input int stall_len, input bit rand_rdy,
                            input bit noisy, input bit hold);
        int cyc, hs_cnt, last_hs, first_v, stall_cnt, prev_w, sum, best_v;
        bit fin, rdy, step_ok;
        exp_t e;
        logic signed [ACC_W-1:0] t, sv_acc;
        logic [OW-1:0]   sv_idx;
        logic [AW_W-1:0] sv_w;
        logic [AW_A-1:0] sv_a;
        exp_class = 0;
        best_v = 0;
        for (int o = 0; o < N_OUT; o++) begin
            sum = 0;
            for (int i = 0; i < N_IN; i++) sum += int'(act_mem[i]) * int'(w_mem[o*N_IN + i]);
            t = sum[ACC_W-1:0];
            e.idx = o;
            e.acc = int'(t);
            exp_q.push_back(e);
            if (o == 0 || e.acc > best_v) begin
                best_v = e.acc;
                exp_class = o;
            end
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("busy_rise", 64'(busy), 64'(1));
        start = hold;
        cyc = 0; hs_cnt = 0; last_hs = -10; first_v = -1; stall_cnt = 0; fin = 0;
        prev_w = int'(w_addr);
        while (!fin && cyc < 2000) begin
            if (busy) begin
                check("w_addr_map", 64'(w_addr), 64'(int'(out_idx)*N_IN + int'(act_addr)));
                step_ok = ((int'(w_addr) - prev_w) inside {0, 1});
                check("w_addr_step", 64'(step_ok), 64'(1));
                prev_w = int'(w_addr);
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) begin
                fin = 1;
                start = hold;
                check("class_idx", 64'(class_idx), 64'(exp_class));
                check("hs_count", 64'(hs_cnt), 64'(N_OUT));
                check("done_after_hs", 64'(cyc - last_hs), 64'(1));
                if (!rand_rdy && stall_len == 0)
                    check("pass_cycles", 64'(cyc), 64'(N_OUT*(N_IN+2)));
            end else begin
                if (noisy) start = 1'($urandom_range(0, 1));
                if (stall_cnt > 0 && stall_cnt < stall_len) begin
                    check("stall_valid", 64'(out_valid), 64'(1));
                    check("stall_acc", 64'(out_acc), 64'(sv_acc));
                    check("stall_idx", 64'(out_idx), 64'(sv_idx));
                    check("stall_w_addr", 64'(w_addr), 64'(sv_w));
                    check("stall_act_addr", 64'(act_addr), 64'(sv_a));
                    rdy = 1'b0;
                    stall_cnt++;
                end else if (stall_cnt == 0 && out_valid && int'(out_idx) == stall_n && stall_len > 0) begin
                    sv_acc = out_acc; sv_idx = out_idx; sv_w = w_addr; sv_a = act_addr;
                    rdy = 1'b0;
                    stall_cnt = 1;
                end else begin
                    rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                out_ready = rdy;
                if (out_valid && rdy) begin
                    check("queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_idx", 64'(out_idx), 64'(e.idx));
                        check("out_acc", 64'(out_acc), 64'(e.acc));
                    end
                    hs_cnt++;
                    last_hs = cyc;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("pass_timeout", 64'(0), 64'(1));
        if (fin) check("first_valid_latency", 64'(first_v), 64'(N_IN + 1));
        out_ready = 1'b1;
        @(negedge clk);
        check("done_pulse_end", 64'(done), 64'(0));
        check("idle_after_fin", 64'(busy), 64'(0));
    endtask

    initial begin
        int w3[3];
        bit found, seen_done;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N_IN; i++) act_mem[i] = 8'sd0;
        for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 4'sd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Per-neuron constant weights cycling -8, 1, 7: ties among the 7s keep the lowest index.
        w3[0] = -8; w3[1] = 1; w3[2] = 7;
        for (int i = 0; i < N_IN; i++) act_mem[i] = 8'sd127;
        for (int o = 0; o < N_OUT; o++)
            for (int i = 0; i < N_IN; i++) w_mem[o*N_IN + i] = 4'(w3[o % 3]);
        run_pass(-1, 0, 0, 0, 0);
        check("basic_class_lowest_tie", 64'(class_idx), 64'(2));

        for (int i = 0; i < N_IN; i++) act_mem[i] = -8'sd128;
        for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = -4'sd8;
        run_pass(-1, 0, 0, 0, 0);
        check("extreme_class_all_tie", 64'(class_idx), 64'(0));

        fill_rand();
        run_pass(1, 5, 0, 0, 0);

        // Reset at i=2 of neuron 1, then a clean pass.
        fill_rand();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (busy && !out_valid && out_idx == OW'(1) && act_addr == AW_A'(2)) found = 1;
            else @(negedge clk);
        end
        check("midrun_point_found", 64'(found), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        seen_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("no_done_after_abort", 64'(seen_done), 64'(0));
        exp_q.delete();
        run_pass(-1, 0, 0, 0, 0);

        fill_rand();
        run_pass(-1, 0, 0, 1, 0);

        fill_rand();
        run_pass(-1, 0, 0, 0, 1);
        run_pass(-1, 0, 0, 0, 0);

        for (int p = 0; p < 200; p++) begin
            fill_rand();
            run_pass(-1, 0, 1, p[0], 0);
        end

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
